// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, register-map addresses and master FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] BYTE = 3'd0;
  localparam logic [2:0] HALF = 3'd1;
  localparam logic [2:0] WORD = 3'd2;

  localparam int unsigned ERR_STATUS = 1;
  localparam int unsigned PAYLOAD    = 2;
  localparam int unsigned PAYLOAD_HI = 3;
  localparam int unsigned DATA_SIZE  = 4;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } mst_state_e;

endpackage

// File: rtl/ahb_lite_master_ctrl.sv
// AHB-Lite single-transfer initiator: valid/ready commands become pipelined NONSEQ
// transfers with an address slot overlapping the previous data slot.
module ahb_lite_master_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned HADDR_W = 3,
  parameter int unsigned HDATA_W = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [HADDR_W-1:0] cmd_addr,
  input  logic [2:0]         cmd_size,
  input  logic [HDATA_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic               rsp_write,
  output logic [HDATA_W-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               hsel,
  output logic [HADDR_W-1:0] haddr,
  output logic [1:0]         htrans,
  output logic               hwrite,
  output logic [2:0]         hsize,
  output logic [HDATA_W-1:0] hwdata,
  input  logic [HDATA_W-1:0] hrdata,
  input  logic               hready,
  input  logic               hresp
);

  mst_state_e         r_state, w_state_d;
  logic               r_a_valid, w_a_valid_d;
  logic               r_a_write;
  logic [HADDR_W-1:0] r_a_addr;
  logic [2:0]         r_a_size;
  logic [HDATA_W-1:0] r_a_wdata;
  logic               r_d_valid;
  logic               r_d_write;
  logic [HDATA_W-1:0] r_hwdata;
  logic               r_hsel;
  logic [1:0]         r_htrans;
  logic               r_rsp_valid, r_rsp_write, r_rsp_err;
  logic [HDATA_W-1:0] r_rsp_rdata;

  logic w_adv, w_done, w_accept, w_issue_d;

  assign w_adv     = hready && (r_state == RUN);
  assign w_done    = hready && r_d_valid;
  assign cmd_ready = !r_a_valid || w_adv;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      RUN:     if (r_d_valid && hresp && !hready) w_state_d = ERR;
      ERR:     if (hready) w_state_d = RUN;
      default: w_state_d = RUN;
    endcase
    w_a_valid_d = r_a_valid;
    if (w_accept) begin
      w_a_valid_d = 1'b1;
    end else if (w_adv) begin
      w_a_valid_d = 1'b0;
    end
    // ERR masks the retained address slot so it is re-presented after recovery.
    w_issue_d = w_a_valid_d && (w_state_d == RUN);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= RUN;
      r_a_valid <= 1'b0;
      r_a_write <= 1'b0;
      r_a_addr  <= '0;
      r_a_size  <= '0;
      r_a_wdata <= '0;
      r_hsel    <= 1'b0;
      r_htrans  <= IDLE;
    end else begin
      r_state   <= w_state_d;
      r_a_valid <= w_a_valid_d;
      if (w_accept) begin
        r_a_write <= cmd_write;
        r_a_addr  <= cmd_addr;
        r_a_size  <= cmd_size;
        r_a_wdata <= cmd_wdata;
      end
      r_hsel   <= w_issue_d;
      r_htrans <= w_issue_d ? NONSEQ : IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_hwdata  <= '0;
    end else if (w_adv) begin
      r_d_valid <= r_a_valid;
      if (r_a_valid) begin
        r_d_write <= r_a_write;
        r_hwdata  <= r_a_wdata;
      end
    end else if (w_done) begin
      r_d_valid <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_done;
      r_rsp_write <= w_done && r_d_write;
      r_rsp_err   <= w_done && hresp;
      r_rsp_rdata <= (w_done && !r_d_write && !hresp) ? hrdata : '0;
    end
  end

  assign hsel      = r_hsel;
  assign htrans    = r_htrans;
  assign haddr     = r_a_addr;
  assign hwrite    = r_a_write;
  assign hsize     = r_a_size;
  assign hwdata    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ahb_lite_master_ctrl.sv
// Bench for ahb_lite_master_ctrl: directed cycle table, async reset sequence and
// a randomized run against a transaction-level command/response model.
module tb_ahb_lite_master_ctrl;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr, cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite;
  logic [2:0]  haddr, hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_lite_master_ctrl #(.HADDR_W(3), .HDATA_W(32)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // One row = inputs held for a cycle plus the outputs expected in that cycle.
  typedef struct {
    logic        cv, cw;
    logic [2:0]  ca, cs;
    logic [31:0] cd;
    logic        rdy, rsp;
    logic [31:0] rd;
    logic        x_a, x_wr;
    logic [2:0]  x_addr, x_size;
    logic        x_wd_chk;
    logic [31:0] x_wd;
    logic        x_rv, x_rw, x_re;
    logic [31:0] x_rdata;
    logic        x_cr;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;

  task automatic nr();
    vec_t v;
    v = '{default: '0};
    v.rdy  = 1'b1;
    v.x_cr = 1'b1;
    tv[nv] = v;
    nv++;
  endtask

  task automatic c(input logic w, input logic [2:0] a, input logic [2:0] s,
                   input logic [31:0] d);
    tv[nv-1].cv = 1'b1; tv[nv-1].cw = w; tv[nv-1].ca = a; tv[nv-1].cs = s; tv[nv-1].cd = d;
  endtask

  task automatic ap(input logic [2:0] a, input logic w, input logic [2:0] s);
    tv[nv-1].x_a = 1'b1; tv[nv-1].x_addr = a; tv[nv-1].x_wr = w; tv[nv-1].x_size = s;
  endtask

  task automatic wd(input logic [31:0] d);
    tv[nv-1].x_wd_chk = 1'b1; tv[nv-1].x_wd = d;
  endtask

  task automatic rs(input logic w, input logic e, input logic [31:0] d);
    tv[nv-1].x_rv = 1'b1; tv[nv-1].x_rw = w; tv[nv-1].x_re = e; tv[nv-1].x_rdata = d;
  endtask

  task automatic bs(input logic r, input logic e, input logic [31:0] d);
    tv[nv-1].rdy = r; tv[nv-1].rsp = e; tv[nv-1].rd = d;
  endtask

  task automatic nc();
    tv[nv-1].x_cr = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int i);
    string t;
    t = $sformatf("row%0d", i);
    cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_size = v.cs; cmd_wdata = v.cd;
    hready = v.rdy; hresp = v.rsp; hrdata = v.rd;
    #1;
    chk({t, ".htrans"}, htrans, v.x_a ? T_NONSEQ : T_IDLE);
    chk({t, ".hsel"}, hsel, v.x_a);
    if (v.x_a) begin
      chk({t, ".haddr"}, haddr, v.x_addr);
      chk({t, ".hwrite"}, hwrite, v.x_wr);
      chk({t, ".hsize"}, hsize, v.x_size);
    end
    if (v.x_wd_chk) chk({t, ".hwdata"}, hwdata, v.x_wd);
    chk({t, ".rsp_valid"}, rsp_valid, v.x_rv);
    if (v.x_rv) begin
      chk({t, ".rsp_write"}, rsp_write, v.x_rw);
      chk({t, ".rsp_err"}, rsp_err, v.x_re);
      chk({t, ".rsp_rdata"}, rsp_rdata, v.x_rdata);
    end
    chk({t, ".cmd_ready"}, cmd_ready, v.x_cr);
    @(posedge hclk);
    #1;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  a, s;
    logic [31:0] d;
  } cmd_t;

  cmd_t        cq[$];
  cmd_t        dp, off;
  logic        dp_v, err2, holding, exp_cr, acc, take, done;
  logic        xrv, xrw, xre;
  logic [31:0] xrd;
  int          n_acc, n_rsp, r;

  initial begin
    hresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    #12;
    chk("rst.htrans", htrans, T_IDLE);
    chk("rst.hsel", hsel, 1'b0);
    chk("rst.haddr", haddr, 3'd0);
    chk("rst.hwrite", hwrite, 1'b0);
    chk("rst.hsize", hsize, 3'd0);
    chk("rst.hwdata", hwdata, 32'd0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_err", rsp_err, 1'b0);
    chk("rst.rsp_write", rsp_write, 1'b0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    #1 hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // single write, zero-wait
    nr(); c(1, 2, 2, 32'hA5A55A5A);
    nr(); ap(2, 1, 2);
    nr(); wd(32'hA5A55A5A);
    nr(); rs(1, 0, 0);
    nr();
    // back-to-back writes then a read
    nr(); c(1, 2, 2, 32'h11111111);
    nr(); c(1, 3, 2, 32'h22222222); ap(2, 1, 2);
    nr(); c(1, 4, 2, 32'h33333333); ap(3, 1, 2); wd(32'h11111111);
    nr(); c(0, 1, 1, 0); ap(4, 1, 2); wd(32'h22222222); rs(1, 0, 0);
    nr(); ap(1, 0, 1); wd(32'h33333333); rs(1, 0, 0);
    nr(); bs(1, 0, 32'h3); rs(1, 0, 0);
    nr(); rs(0, 0, 32'h3);
    // read with three wait states and a queued write
    nr(); c(0, 4, 2, 0);
    nr(); c(1, 2, 2, 32'h55); ap(4, 0, 2);
    for (int k = 0; k < 3; k++) begin
      nr(); c(1, 3, 2, 32'h66); ap(2, 1, 2); bs(0, 0, 0); nc();
    end
    nr(); c(1, 3, 2, 32'h66); ap(2, 1, 2); bs(1, 0, 32'h1234);
    nr(); ap(3, 1, 2); wd(32'h55); rs(0, 0, 32'h1234);
    nr(); wd(32'h66); rs(1, 0, 0);
    nr(); rs(1, 0, 0);
    // single-cycle error on a read, stray hresp while no data phase
    nr(); c(0, 5, 2, 0);
    nr(); ap(5, 0, 2); bs(1, 1, 0);
    nr(); bs(1, 1, 32'hDEADBEEF);
    nr(); rs(0, 1, 0); c(1, 3, 2, 32'h77);
    nr(); ap(3, 1, 2);
    nr(); wd(32'h77);
    nr(); rs(1, 0, 0);
    // two-cycle error on a write with a read waiting in the address slot
    nr(); c(1, 1, 2, 32'hABCD);
    nr(); c(0, 2, 2, 0); ap(1, 1, 2);
    nr(); ap(2, 0, 2); wd(32'hABCD); bs(0, 1, 0); nc();
    nr(); wd(32'hABCD); bs(1, 1, 0); nc();
    nr(); ap(2, 0, 2); rs(1, 1, 0);
    nr(); bs(1, 0, 32'hBEEF);
    nr(); rs(0, 0, 32'hBEEF);
    nr();

    for (int i = 0; i < nv; i++) apply(tv[i], i);

    // reset asserted during a data phase
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_size = 3'd2; cmd_wdata = 32'hC;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h42;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    chk("arst.htrans", htrans, T_IDLE);
    chk("arst.hsel", hsel, 1'b0);
    chk("arst.rsp_valid", rsp_valid, 1'b0);
    @(posedge hclk); #1;
    chk("arst.rsp_valid_held", rsp_valid, 1'b0);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    chk("arst.rsp_valid_after", rsp_valid, 1'b0);
    chk("arst.htrans_after", htrans, T_IDLE);
    chk("arst.cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2; cmd_size = 3'd2; cmd_wdata = '0;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    #1;
    chk("arst.fresh_htrans", htrans, T_NONSEQ);
    chk("arst.fresh_haddr", haddr, 3'd2);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    chk("arst.fresh_rsp_valid", rsp_valid, 1'b1);
    chk("arst.fresh_rsp_rdata", rsp_rdata, 32'h42);
    chk("arst.fresh_rsp_err", rsp_err, 1'b0);
    @(posedge hclk); #1;

    // randomized traffic against the command/response model
    dp_v = 1'b0; err2 = 1'b0; holding = 1'b0; xrv = 1'b0; xrw = 1'b0; xre = 1'b0; xrd = '0;
    n_acc = 0; n_rsp = 0;
    dp = '{default: '0}; off = '{default: '0};
    for (int cyc = 0; cyc < 2600; cyc++) begin
      chk("rnd.rsp_valid", rsp_valid, xrv);
      if (rsp_valid) n_rsp++;
      if (xrv) begin
        chk("rnd.rsp_write", rsp_write, xrw);
        chk("rnd.rsp_err", rsp_err, xre);
        chk("rnd.rsp_rdata", rsp_rdata, xrd);
      end
      if (dp_v && dp.w) chk("rnd.hwdata", hwdata, dp.d);
      chk("rnd.htrans", htrans, (cq.size() != 0 && !err2) ? T_NONSEQ : T_IDLE);
      chk("rnd.hsel", hsel, cq.size() != 0 && !err2);
      if (cq.size() != 0 && !err2) begin
        chk("rnd.haddr", haddr, cq[0].a);
        chk("rnd.hwrite", hwrite, cq[0].w);
        chk("rnd.hsize", hsize, cq[0].s);
      end

      if (err2) begin
        hready = 1'b1; hresp = 1'b1;
      end else if (dp_v) begin
        r = $urandom_range(0, 9);
        hready = !(r <= 3);
        hresp  = (r == 3) || (r == 4);
      end else begin
        hready = 1'b1; hresp = 1'($urandom_range(0, 1));
      end
      hrdata = $urandom;
      if (!holding) begin
        cmd_valid = (cyc < 2000) && ($urandom_range(0, 3) != 0);
        off.w = 1'($urandom_range(0, 1));
        off.a = 3'($urandom_range(0, 7));
        off.s = 3'($urandom_range(0, 2));
        off.d = $urandom;
      end
      cmd_write = off.w; cmd_addr = off.a; cmd_size = off.s; cmd_wdata = off.d;
      #1;
      exp_cr = (cq.size() == 0) || (hready && !err2);
      chk("rnd.cmd_ready", cmd_ready, exp_cr);
      acc  = cmd_valid && exp_cr;
      take = hready && (cq.size() != 0) && !err2;
      done = hready && dp_v;

      @(posedge hclk); #1;
      xrv = done;
      xrw = done && dp.w;
      xre = done && hresp;
      xrd = (done && !dp.w && !hresp) ? hrdata : 32'd0;
      err2 = dp_v && hresp && !hready;
      if (done) dp_v = 1'b0;
      if (take) begin
        dp   = cq.pop_front();
        dp_v = 1'b1;
      end
      if (acc) begin
        cq.push_back(off);
        n_acc++;
        holding = 1'b0;
      end else begin
        holding = cmd_valid;
      end
    end
    chk("rnd.queue_drained", cq.size(), 0);
    chk("rnd.rsp_count", n_rsp, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
